int_controller: RTL and testbench

Edge-triggered, fixed-priority interrupt controller sitting directly upstream of the coprocessor-0 block. It captures rising edges on external IRQ lines into pending latches, applies a software mask, and drives the single `INT` request into CoPR0. It completes the handshake on CoPR0's registered `INT_ACK`, then holds the source ID stable until the handler retires with `eret`.

---
 rtl/int_ctrl_pkg.sv | 25 ++
 rtl/int_priority_encoder.sv | 37 +++
 rtl/int_controller.sv | 162 ++++++++++++++++
 tb/tb_int_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller that feeds CoPR0:
//   - FSM state encoding (IDLE / REQ / SERVICE)
//   - default number of IRQ lines
//   - ENABLE / DISABLE single-bit constants shared with CoPR0
// ---------------------------------------------------------------------------
package int_ctrl_pkg;

  // Handshake states of the controller. Encoding 2'd3 is unused and
  // recovers to IC_IDLE.
  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

  // Default number of external IRQ lines (legal range 2..8).
  localparam int IC_N_IRQ = 4;

  // Single-bit request levels, shared with CoPR0.
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage : int_ctrl_pkg

// File: rtl/int_priority_encoder.sv
// ---------------------------------------------------------------------------
// int_priority_encoder
// Purely combinational fixed-priority encoder: the lowest set index wins.
// Ports:
//   i_cand [N_IRQ-1:0] : candidate requests (pending and not masked)
//   o_any              : at least one candidate present
//   o_idx  [ID_W-1:0]  : index of the winning candidate (0 when none)
// ---------------------------------------------------------------------------
module int_priority_encoder
  import int_ctrl_pkg::*;
#(
  parameter int N_IRQ = IC_N_IRQ,
  parameter int ID_W  = 2
) (
  input  logic [N_IRQ-1:0] i_cand,
  output logic             o_any,
  output logic [ID_W-1:0]  o_idx
);

  logic w_found;

  // Scan upward and take the first set bit, so the lowest index wins.
  always_comb begin
    w_found = 1'b0;
    o_idx   = {ID_W{1'b0}};
    for (int i = 0; i < N_IRQ; i++) begin
      if (i_cand[i] && !w_found) begin
        o_idx   = ID_W'(i);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule : int_priority_encoder

// File: rtl/int_controller.sv
// ---------------------------------------------------------------------------
// int_controller
// Edge-triggered, fixed-priority interrupt controller in front of CoPR0.
// Rising edges on irq_in set pending latches; unmasked pending sources are
// arbitrated lowest-index-first and presented to CoPR0 through INT. The
// request completes on CoPR0's registered INT_ACK; the source ID then stays
// stable until the handler returns with eret.
//
// Ports:
//   clk        : single clock, rising edge active
//   reset      : asynchronous, active-low reset
//   irq_in     : external request lines (rising edge = event)
//   INT        : registered interrupt request to CoPR0
//   INT_ACK    : acknowledge from CoPR0 (registered by CoPR0)
//   eret       : handler return
//   mask_we    : mask write strobe
//   mask_wdata : new mask value (1 = masked)
//   mask       : current mask
//   pending    : pending latches
//   irq_id     : ID of the source requested or being serviced
//   in_service : high while a handler is running
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int N_IRQ = IC_N_IRQ,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             INT,
  input  logic             INT_ACK,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pending,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service
);

  // State and output registers
  ic_state_e        r_state;
  logic [N_IRQ-1:0] r_irq_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [ID_W-1:0]  r_irq_id;
  logic             r_int;
  logic             r_in_service;

  // Combinational next-state values
  ic_state_e        w_state_nxt;
  logic [ID_W-1:0]  w_irq_id_nxt;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_cand;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic             w_pe_any;
  logic [ID_W-1:0]  w_pe_idx;

  // Edge detect against last cycle's sample; arbitration only ever sees
  // registered pending/mask so the request path stays flop-to-flop.
  assign w_rise = irq_in & ~r_irq_prev;
  assign w_cand = r_pending & ~r_mask;

  int_priority_encoder #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio (
    .i_cand (w_cand),
    .o_any  (w_pe_any),
    .o_idx  (w_pe_idx)
  );

  // Next-state, ID capture and pending-clear decode for the handshake FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    w_clr        = {N_IRQ{1'b0}};
    case (r_state)
      IC_IDLE: begin
        // INT_ACK and eret carry no meaning here.
        if (w_pe_any) begin
          w_state_nxt  = IC_REQ;
          w_irq_id_nxt = w_pe_idx;
        end else begin
          w_state_nxt  = IC_IDLE;
        end
      end
      IC_REQ: begin
        // ID is frozen: later, higher-priority arrivals and mask writes
        // wait until the controller is back in IDLE.
        if (INT_ACK) begin
          w_state_nxt = IC_SERVICE;
          w_clr       = {{(N_IRQ-1){1'b0}}, 1'b1} << r_irq_id;
        end else begin
          w_state_nxt = IC_REQ;
        end
      end
      IC_SERVICE: begin
        // Always pass through IDLE, even with another candidate waiting.
        if (eret) begin
          w_state_nxt = IC_IDLE;
        end else begin
          w_state_nxt = IC_SERVICE;
        end
      end
      default: begin
        w_state_nxt = IC_IDLE;
      end
    endcase
    // A new edge overrides the clear from the acknowledge of the same bit.
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
  end

  // FSM state, captured ID and the state-decoded outputs (kept in flops).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IC_IDLE;
      r_irq_id     <= {ID_W{1'b0}};
      r_int        <= DISABLE;
      r_in_service <= DISABLE;
    end else begin
      r_state      <= w_state_nxt;
      r_irq_id     <= w_irq_id_nxt;
      r_int        <= (w_state_nxt == IC_REQ) ? ENABLE : DISABLE;
      r_in_service <= (w_state_nxt == IC_SERVICE) ? ENABLE : DISABLE;
    end
  end

  // Edge-detect history and pending latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_prev <= {N_IRQ{1'b0}};
      r_pending  <= {N_IRQ{1'b0}};
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= w_pending_nxt;
    end
  end

  // Software mask; writable in every state, resets to fully masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= {N_IRQ{1'b1}};
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end else begin
      r_mask <= r_mask;
    end
  end

  assign INT        = r_int;
  assign in_service = r_in_service;
  assign irq_id     = r_irq_id;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule : int_controller

// File: tb/tb_int_controller.sv
// ---------------------------------------------------------------------------
// tb_int_controller
// Directed-vector bench for int_controller (N_IRQ=4, ID_W=2). Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_int_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       INT;
  logic       INT_ACK;
  logic       eret;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic [3:0] pending;
  logic [1:0] irq_id;
  logic       in_service;

  int n_vec;
  int n_err;

  int_controller #(
    .N_IRQ (4),
    .ID_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .INT        (INT),
    .INT_ACK    (INT_ACK),
    .eret       (eret),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    irq_in     = 4'b0000;
    INT_ACK    = 1'b0;
    eret       = 1'b0;
    mask_we    = 1'b0;
    mask_wdata = 4'b0000;
    #1 reset   = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_INT",     {31'd0, INT},        32'd0);
    check("rst_pending", {28'd0, pending},    32'h0);
    check("rst_mask",    {28'd0, mask},       32'hF);
    check("rst_irq_id",  {30'd0, irq_id},     32'd0);
    check("rst_insvc",   {31'd0, in_service}, 32'd0);
    reset = 1'b1;
    tick();

    // T1: basic request / ack / eret timing on irq 2
    write_mask(4'b0000);
    check("t1_mask", {28'd0, mask}, 32'h0);
    irq_in = 4'b0100;
    tick();                                   // edge k
    check("t1_pend_k",  {28'd0, pending}, 32'h4);
    check("t1_INT_k",   {31'd0, INT},     32'd0);
    irq_in = 4'b0000;
    tick();                                   // edge k+1
    check("t1_INT_k1",  {31'd0, INT},     32'd1);
    check("t1_id_k1",   {30'd0, irq_id},  32'd2);
    tick();                                   // edge k+2, still unacked
    check("t1_INT_k2",  {31'd0, INT},     32'd1);
    do_ack();                                 // edge k+3
    check("t1_INT_k3",  {31'd0, INT},        32'd0);
    check("t1_svc_k3",  {31'd0, in_service}, 32'd1);
    check("t1_pend_k3", {28'd0, pending},    32'h0);
    do_eret();
    check("t1_svc_ret", {31'd0, in_service}, 32'd0);
    check("t1_id_hold", {30'd0, irq_id},     32'd2);

    // T2: simultaneous irq 3 and irq 1, lowest index first
    irq_in = 4'b1010;
    tick();
    check("t2_pend", {28'd0, pending}, 32'hA);
    irq_in = 4'b0000;
    tick();
    check("t2_INT1", {31'd0, INT},    32'd1);
    check("t2_id1",  {30'd0, irq_id}, 32'd1);
    do_ack();
    check("t2_pend_after_ack", {28'd0, pending}, 32'h8);
    do_eret();                                // edge m
    check("t2_INT_m",  {31'd0, INT},        32'd0);
    check("t2_svc_m",  {31'd0, in_service}, 32'd0);
    tick();                                   // edge m+1
    check("t2_INT_m1", {31'd0, INT},    32'd1);
    check("t2_id3",    {30'd0, irq_id}, 32'd3);
    do_ack();
    do_eret();
    check("t2_pend_end", {28'd0, pending}, 32'h0);

    // T3: masked pending, then unmask; mask write during REQ keeps INT
    write_mask(4'b1111);
    irq_in = 4'b0001;
    tick();
    check("t3_pend", {28'd0, pending}, 32'h1);
    irq_in = 4'b0000;
    tick();
    check("t3_INT_masked_a", {31'd0, INT}, 32'd0);
    tick();
    check("t3_INT_masked_b", {31'd0, INT}, 32'd0);
    write_mask(4'b0000);
    check("t3_INT_wr", {31'd0, INT}, 32'd0);
    tick();
    check("t3_INT_unmasked", {31'd0, INT},    32'd1);
    check("t3_id0",          {30'd0, irq_id}, 32'd0);
    write_mask(4'b1111);
    check("t3_INT_kept", {31'd0, INT}, 32'd1);
    do_ack();
    check("t3_svc",  {31'd0, in_service}, 32'd1);
    check("t3_pend_clr", {28'd0, pending}, 32'h0);
    do_eret();
    write_mask(4'b0000);

    // T4: no preemption while in REQ
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    check("t4_id2", {30'd0, irq_id}, 32'd2);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    check("t4_id_frozen", {30'd0, irq_id},  32'd2);
    check("t4_INT_hold",  {31'd0, INT},     32'd1);
    check("t4_pend",      {28'd0, pending}, 32'h5);
    do_ack();
    check("t4_pend_ack",  {28'd0, pending}, 32'h1);
    do_eret();
    tick();
    check("t4_INT0", {31'd0, INT},    32'd1);
    check("t4_id0",  {30'd0, irq_id}, 32'd0);
    do_ack();
    do_eret();

    // T5: edge on irq 1 in the cycle its ack clears it -> set wins
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    check("t5_id1", {30'd0, irq_id}, 32'd1);
    irq_in  = 4'b0010;
    INT_ACK = 1'b1;
    tick();
    irq_in  = 4'b0000;
    INT_ACK = 1'b0;
    check("t5_pend_kept", {28'd0, pending},    32'h2);
    check("t5_svc",       {31'd0, in_service}, 32'd1);
    do_eret();
    tick();
    check("t5_reINT", {31'd0, INT},    32'd1);
    check("t5_reid",  {30'd0, irq_id}, 32'd1);

    // T6: reset asserted mid-handshake (currently in REQ for irq 1)
    irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    check("t6_inreq", {31'd0, INT}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_INT_async", {31'd0, INT},        32'd0);
    check("t6_pend",      {28'd0, pending},    32'h0);
    check("t6_mask",      {28'd0, mask},       32'hF);
    check("t6_id",        {30'd0, irq_id},     32'd0);
    check("t6_svc",       {31'd0, in_service}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_INT_after", {31'd0, INT}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_int_controller
